// File: rtl/fp_pkg.sv
// Shared binary32 constants, flag bit positions and the operand-pair type
// used by the fp_mul_stream datapath.
package fp_pkg;

  localparam int WIDTH  = 32;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SIG_W  = MAN_W + 1;
  localparam int BIAS   = 127;
  localparam int FLAG_W = 4;

  localparam logic [WIDTH-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WIDTH-1:0] POS_INF = 32'h7F80_0000;

  localparam int FLAG_NAN    = 0;
  localparam int FLAG_INF    = 1;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_DENORM = 3;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } operand_pair_t;

  function automatic logic is_denormal(input logic [WIDTH-1:0] x);
    return (x[30:23] == '0) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp_mul_stream_if.sv
// Valid/ready operand and product streams of the binary32 multiplier.
interface fp_mul_stream_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_p;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

endinterface

// File: rtl/fp_mul_core.sv
// Combinational binary32 multiply with truncation and special-case override.
// Status flags exist only when FP_MUL_STREAM_FLAGS_EN is defined.
module fp_mul_core
  import fp_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
`ifdef FP_MUL_STREAM_FLAGS_EN
  output logic [FLAG_W-1:0] flags,
`endif
  output logic [WIDTH-1:0]  p
);

  logic             sign;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [SIG_W:0]   prod_hi;
  logic             norm;
  logic [MAN_W-1:0] frac;
  logic [9:0]       exp_sum;

  assign sign   = a[31] ^ b[31];
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
  assign a_zero = (a[30:23] == '0) && (a[22:0] == '0);
  assign b_zero = (b[30:23] == '0) && (b[22:0] == '0);

  // Only bits 47..23 of the 48-bit significand product survive truncation.
  assign prod_hi = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
  assign norm    = prod_hi[24];
  assign frac    = norm ? prod_hi[23:1] : prod_hi[22:0];
  assign exp_sum = 10'(a[30:23]) + 10'(b[30:23]) + 10'(norm) - 10'(BIAS);

  // Exponent out of range clamps to signed zero / infinity; specials win last.
  always_comb begin
    p = {sign, exp_sum[7:0], frac};
    if (exp_sum[9] || exp_sum == '0) begin
      p = {sign, 31'd0};
    end else if (exp_sum >= 10'd255) begin
      p = {sign, POS_INF[30:0]};
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = QNAN;
    end else if (a_inf || b_inf) begin
      p = {sign, POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      p = {sign, 31'd0};
    end
  end

`ifdef FP_MUL_STREAM_FLAGS_EN
  always_comb begin
    flags              = '0;
    flags[FLAG_NAN]    = (p == QNAN);
    flags[FLAG_INF]    = (p[30:0] == POS_INF[30:0]);
    flags[FLAG_ZERO]   = (p[30:0] == 31'd0);
    flags[FLAG_DENORM] = is_denormal(a) | is_denormal(b);
  end
`endif

endmodule

// File: rtl/fp_mul_stream.sv
// Two-stage valid/ready binary32 multiplier: S1 holds operands, S2 the product.
// Define FP_MUL_STREAM_FLAGS_EN to add the registered out_flags status port.
module fp_mul_stream
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fp_mul_stream_if.slave     stream,
`ifdef FP_MUL_STREAM_FLAGS_EN
  output logic [FLAG_W-1:0]  out_flags,
`endif
  output logic [15:0]        op_count,
  output logic               busy
);

  logic          s1_valid;
  logic          s2_valid;
  operand_pair_t s1_ops;
  logic          accept;
  logic          advance;
  logic          consume;
  logic [WIDTH-1:0] core_p;
`ifdef FP_MUL_STREAM_FLAGS_EN
  logic [FLAG_W-1:0] core_flags;
`endif

  fp_mul_core u_core (
    .a     (s1_ops.a),
    .b     (s1_ops.b),
`ifdef FP_MUL_STREAM_FLAGS_EN
    .flags (core_flags),
`endif
    .p     (core_p)
  );

  // Ready never looks at in_valid, so upstream can wait on it safely.
  assign stream.in_ready  = !s1_valid | !s2_valid | stream.out_ready;
  assign stream.out_valid = s2_valid;
  assign busy             = s1_valid | s2_valid;

  assign accept  = stream.in_valid & stream.in_ready;
  assign consume = s2_valid & stream.out_ready;
  assign advance = s1_valid & (!s2_valid | stream.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_ops       <= '0;
      s2_valid     <= 1'b0;
      stream.out_p <= '0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_ops.a <= stream.in_a;
        s1_ops.b <= stream.in_b;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      if (advance) begin
        s2_valid     <= 1'b1;
        stream.out_p <= core_p;
      end else if (consume) begin
        s2_valid <= 1'b0;
      end
      if (consume) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

`ifdef FP_MUL_STREAM_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags <= '0;
    end else if (advance) begin
      out_flags <= core_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_stream.sv
// Randomised self-checking bench for fp_mul_stream against a behavioural
// binary32 truncating-multiply model; honours FP_MUL_STREAM_FLAGS_EN.
module tb_fp_mul_stream;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op_count;
  logic        busy;
`ifdef FP_MUL_STREAM_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  expf_q[$];

  fp_mul_stream_if bus ();

  fp_mul_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stream   (bus),
`ifdef FP_MUL_STREAM_FLAGS_EN
    .out_flags(out_flags),
`endif
    .op_count (op_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: real-number product of 1.m significands, truncated.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic s;
    bit an, bn, ai, bi, az, bz;
    longint unsigned prod, frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0) && (a[22:0] == 0);
    bz = (eb == 0) && (b[22:0] == 0);
    s  = a[31] ^ b[31];
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 31'h7F800000};
    if (az || bz) return {s, 31'h0};
    prod = (64'd8388608 + 64'(a[22:0])) * (64'd8388608 + 64'(b[22:0]));
    e = ea + eb - 127;
    if (prod >= (64'd1 << 47)) begin
      prod = prod / 2;
      e = e + 1;
    end
    frac = (prod / 64'd8388608) - 64'd8388608;
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], frac[22:0]};
  endfunction

  function automatic logic [3:0] model_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  f;
    r    = model_mul(a, b);
    f[0] = (r == 32'h7FC00000);
    f[1] = (r[30:0] == 31'h7F800000);
    f[2] = (r[30:0] == 31'h0);
    f[3] = ((a[30:23] == 0) && (a[22:0] != 0)) || ((b[30:23] == 0) && (b[22:0] != 0));
    return f;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       return {r[31], 31'd0};
      1:       return {r[31], 8'hFF, 23'd0};
      2:       return {r[31], 8'hFF, r[22:1], 1'b1};
      3:       return {r[31], 8'h00, r[22:1], 1'b1};
      4:       return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
    endcase
  endfunction

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    if (op_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_op_count got=%h want=0000", op_count); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    if (bus.out_p !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_p got=%h want=00000000", bus.out_p); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_latency();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 32'h3FC00000; bus.in_b = 32'h40000000; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early got=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid got=%b want=1", bus.out_valid); end
    if (bus.out_p !== 32'h40400000) begin errors++; $display("[TB] FAIL mul_1p5x2 got=%h want=40400000", bus.out_p); end
    @(posedge clk); #1;
    checks += 2;
    if (op_count !== 16'd1) begin errors++; $display("[TB] FAIL op_count_one got=%h want=0001", op_count); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained_valid got=%b want=0", bus.out_valid); end
    idle(2);
  endtask

  task automatic test_specials();
    logic [31:0] ta[11] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 32'h80000000, 32'h7F800001,
                            32'h3F800000, 32'h7F000000, 32'h00800000, 32'h3FFFFFFF, 32'h00400000,
                            32'h7F800000};
    logic [31:0] tb_[11] = '{32'h00000000, 32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h7F000000, 32'h00800000, 32'h3FFFFFFF, 32'h3F800000,
                             32'hFF800000};
    logic [31:0] tp[11] = '{32'h7FC00000, 32'hC0C00000, 32'hFF800000, 32'h80000000, 32'h7FC00000,
                            32'h3F800000, 32'h7F800000, 32'h00000000, 32'h407FFFFE, 32'h00000000,
                            32'hFF800000};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = ta[i]; bus.in_b = tb_[i]; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL special_valid[%0d] got=%b want=1", i, bus.out_valid); end
      if (bus.out_p !== tp[i]) begin errors++; $display("[TB] FAIL special_p[%0d] %h*%h got=%h want=%h", i, ta[i], tb_[i], bus.out_p, tp[i]); end
`ifdef FP_MUL_STREAM_FLAGS_EN
      checks++;
      if (out_flags !== model_flags(ta[i], tb_[i])) begin
        errors++; $display("[TB] FAIL special_flags[%0d] got=%b want=%b", i, out_flags, model_flags(ta[i], tb_[i]));
      end
      if (i == 0) begin
        checks++;
        if (out_flags[0] !== 1'b1) begin errors++; $display("[TB] FAIL inf_x_zero_nan_flag got=%b want=1", out_flags[0]); end
      end
`endif
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[4], b[4];
    int idx = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    @(negedge clk);
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.in_valid  = (idx < 4);
      bus.in_a      = a[idx % 4];
      bus.in_b      = b[idx % 4];
      bus.out_ready = (cyc >= 6);
      #1;
      if (cyc >= 2 && cyc < 6) begin
        checks += 4;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b want=0", cyc, bus.in_ready); end
        if (idx != 2) begin errors++; $display("[TB] FAIL b2b_accepts cyc=%0d got=%0d want=2", cyc, idx); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold_valid cyc=%0d got=%b want=1", cyc, bus.out_valid); end
        if (bus.out_p !== model_mul(a[0], b[0])) begin
          errors++; $display("[TB] FAIL b2b_hold_p cyc=%0d got=%h want=%h", cyc, bus.out_p, model_mul(a[0], b[0]));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_p !== model_mul(a[got], b[got])) begin
          errors++; $display("[TB] FAIL b2b_order[%0d] got=%h want=%h", got, bus.out_p, model_mul(a[got], b[got]));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
    end
    checks += 2;
    if (got != 4) begin errors++; $display("[TB] FAIL b2b_drained got=%0d want=4", got); end
    if (idx != 4) begin errors++; $display("[TB] FAIL b2b_accepted got=%0d want=4", idx); end
    idle(3);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_duplicate got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] a = '0, b = '0, held = '0;
    bit pend = 0, holding = 0;
    int guard = 0;
    exp_q.delete(); expf_q.delete();
    @(negedge clk);
    for (int cyc = 0; cyc < 400 || exp_q.size() > 0 || busy; cyc++) begin
      if (cyc < 400 && !pend && $urandom_range(0, 9) < 7) begin
        a = rand_operand(); b = rand_operand(); pend = 1;
      end
      bus.in_valid  = pend;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      #1;
      if (holding) begin
        checks++;
        if (!bus.out_valid || bus.out_p !== held) begin
          errors++; $display("[TB] FAIL rand_hold got=%b/%h want=1/%h", bus.out_valid, bus.out_p, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra got=%h want=none", bus.out_p);
        end else begin
          if (bus.out_p !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_p got=%h want=%h", bus.out_p, exp_q[0]); end
`ifdef FP_MUL_STREAM_FLAGS_EN
          checks++;
          if (out_flags !== expf_q[0]) begin errors++; $display("[TB] FAIL rand_flags got=%b want=%b", out_flags, expf_q[0]); end
`endif
          void'(exp_q.pop_front()); void'(expf_q.pop_front());
        end
      end
      holding = bus.out_valid && !bus.out_ready;
      held    = bus.out_p;
      if (pend && bus.in_ready) begin
        exp_q.push_back(model_mul(a, b)); expf_q.push_back(model_flags(a, b)); pend = 0;
      end
      @(negedge clk);
      guard++;
      if (guard > 600) break;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_timeout left=%0d want=0", exp_q.size()); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 32'h3F800000; bus.in_b = 32'h40000000; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_full_busy got=%b want=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    if (op_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_op_count got=%h want=0000", op_count); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 32'h40400000; bus.in_b = 32'h40400000; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_latency_early got=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_latency got=%b want=1", bus.out_valid); end
    if (bus.out_p !== 32'h41100000) begin errors++; $display("[TB] FAIL mid_3x3 got=%h want=41100000", bus.out_p); end
    idle(2);
  endtask

  task automatic test_wrap();
    int acc = 0, hs = 0, guard = 0;
    bit seen_ffff = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    while (hs < 65536 && guard < 70000) begin
      bus.in_valid  = (acc < 65536);
      bus.in_a      = 32'h3F800000;
      bus.in_b      = 32'h40000000;
      bus.out_ready = 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid && bus.out_ready) hs++;
      @(posedge clk); #1;
      if (hs == 65535 && !seen_ffff) begin
        seen_ffff = 1;
        checks++;
        if (op_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_ffff got=%h want=ffff", op_count); end
      end
      guard++;
      @(negedge clk);
    end
    checks += 2;
    if (hs != 65536) begin errors++; $display("[TB] FAIL wrap_timeout got=%0d want=65536", hs); end
    if (op_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero got=%h want=0000", op_count); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_specials();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
